bitserial_alu: RTL and testbench

- WIDTH-bit ALU that reuses a single 1-bit ALU slice serially, LSB first, one bit per clock.
- Operation set and control encoding match the team's 1-bit ALU: AND, OR, NOR, NAND, ADD, SUBTRACT.
- Adds a start/busy/done handshake, word-wide flags, and a full-word unsigned compare operation.
- Sits in the datapath where area matters more than latency, fed by a controller that issues one operation at a time.

---
 rtl/bitserial_alu_if.sv | 38 +++
 rtl/bitserial_alu.sv | 149 ++++++++++++++
 tb/tb_bitserial_alu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bitserial_alu_if.sv
// rtl/bitserial_alu_if.sv - request/response bundle between the controller and bitserial_alu.
// BITSERIAL_ALU_OVERFLOW_EN adds the overflow flag.
interface bitserial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ainv;
  logic             binv;
  logic             carryin;
  logic [1:0]       operation;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             sgt;
`ifdef BITSERIAL_ALU_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, ainv, binv, carryin, operation,
    input  busy, done, result, carryout, zero, sgt
`ifdef BITSERIAL_ALU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, ainv, binv, carryin, operation,
    output busy, done, result, carryout, zero, sgt
`ifdef BITSERIAL_ALU_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/bitserial_alu.sv
// rtl/bitserial_alu.sv - WIDTH-bit ALU built from one 1-bit slice stepped LSB first.
// BITSERIAL_ALU_OVERFLOW_EN enables the signed overflow flag for SUM.
module bitserial_alu #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           resetn,
  bitserial_alu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ainv_q, ainv_d, binv_q, binv_d;
  logic [1:0]       op_q, op_d;
  logic             c_q, c_d, gt_q, gt_d;
  logic             carryout_q, carryout_d, zero_q, zero_d, sgt_q, sgt_d;
  logic             ovf_q, ovf_d;

  logic             ai, bi, sum_bit, res_bit, c_next, gt_next, accept;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    ai      = a_q[0] ^ ainv_q;
    bi      = b_q[0] ^ binv_q;
    sum_bit = ai ^ bi ^ c_q;
    c_next  = ((ai ^ bi) & c_q) | (ai & bi);
    // Compare on raw operand bits; later (higher) bits override earlier ones.
    gt_next = (a_q[0] & ~b_q[0]) | (~(a_q[0] ^ b_q[0]) & gt_q);
    case (op_q)
      2'b00:   res_bit = ai & bi;
      2'b01:   res_bit = ai | bi;
      2'b10:   res_bit = sum_bit;
      default: res_bit = 1'b0;
    endcase
    final_res = (op_q == 2'b11) ? {{(WIDTH-1){1'b0}}, gt_next}
                                : {res_bit, res_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    a_d        = a_q;
    b_d        = b_q;
    res_sh_d   = res_sh_q;
    result_d   = result_q;
    ainv_d     = ainv_q;
    binv_d     = binv_q;
    op_d       = op_q;
    c_d        = c_q;
    gt_d       = gt_q;
    carryout_d = carryout_q;
    zero_d     = zero_q;
    sgt_d      = sgt_q;
    ovf_d      = ovf_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: accept = bus.start;
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_sh_d = {res_bit, res_sh_q[WIDTH-1:1]};
        c_d      = c_next;
        gt_d     = gt_next;
        if (count_q == LAST) begin
          state_d    = DONE;
          result_d   = final_res;
          carryout_d = c_next;
          zero_d     = ~|final_res;
          sgt_d      = gt_next;
          ovf_d      = (op_q == 2'b10) & (c_q ^ c_next);
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        accept  = bus.start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = RUN;
      count_d = '0;
      a_d     = bus.a;
      b_d     = bus.b;
      ainv_d  = bus.ainv;
      binv_d  = bus.binv;
      op_d    = bus.operation;
      c_d     = bus.carryin;
      gt_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_sh_q   <= '0;
      result_q   <= '0;
      ainv_q     <= 1'b0;
      binv_q     <= 1'b0;
      op_q       <= 2'b00;
      c_q        <= 1'b0;
      gt_q       <= 1'b0;
      carryout_q <= 1'b0;
      zero_q     <= 1'b0;
      sgt_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_sh_q   <= res_sh_d;
      result_q   <= result_d;
      ainv_q     <= ainv_d;
      binv_q     <= binv_d;
      op_q       <= op_d;
      c_q        <= c_d;
      gt_q       <= gt_d;
      carryout_q <= carryout_d;
      zero_q     <= zero_d;
      sgt_q      <= sgt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.carryout = carryout_q;
  assign bus.zero     = zero_q;
  assign bus.sgt      = sgt_q;
`ifdef BITSERIAL_ALU_OVERFLOW_EN
  assign bus.overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_bitserial_alu.sv
// tb/tb_bitserial_alu.sv - directed vector bench for bitserial_alu at WIDTH=8.
module tb_bitserial_alu;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bitserial_alu_if #(.WIDTH(8)) bus ();
  bitserial_alu #(.WIDTH(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] op;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       sgt;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ainv,
                       input logic binv, input logic cin, input logic [1:0] op);
    bus.a = a; bus.b = b; bus.ainv = ainv; bus.binv = binv;
    bus.carryin = cin; bus.operation = op;
  endtask

  // Pulses start for one edge; lat = edges counted from the start edge (inclusive) to done.
  task automatic run_op(input vec_t v, output int lat);
    @(negedge clk);
    drive(v.a, v.b, v.ainv, v.binv, v.cin, v.op);
    bus.start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) break;
    end
  endtask

  int   lat, busy_n, done_n, t;
  vec_t v;

  initial begin
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b10, 8'h4B, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 8'hCC, 1'b1, 1'b1, 1'b0, 2'b01, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hF0, 8'hCC, 1'b1, 1'b1, 1'b0, 2'b00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 2'b11, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.start = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.carryout, bus.zero, bus.sgt}, 0);
    resetn = 1'b1;

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    drive(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b10);
    bus.start = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      bus.start = (k == 3);
      if (k == 3) drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 2'b00);
    end
    chk("midrun_busy_cycles", busy_n, 8);
    chk("midrun_done_count", done_n, 1);
    chk("midrun_result", bus.result, 8'h4B);
    chk("hold_done_low", bus.done, 0);

    // start held through DONE launches a back-to-back op
    @(negedge clk);
    drive(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b10);
    bus.start = 1'b1;
    t = 0;
    while (t < 20) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (bus.done) break;
    end
    chk("b2b_first_latency", t, 9);
    chk("b2b_first_result", bus.result, 8'h4B);
    drive(8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 2'b10);
    t = 0;
    while (t < 20) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) break;
    end
    chk("b2b_second_gap", t, 9);
    chk("b2b_second_result", bus.result, 8'h00);
    chk("b2b_second_zero", bus.zero, 1);

    // abort with reset at count=3, leaving nonzero flags beforehand
    v = vecs[1];
    run_op(v, lat);
    @(negedge clk);
    drive(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b10);
    bus.start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_flags", {bus.carryout, bus.zero, bus.sgt}, 0);
`ifdef BITSERIAL_ALU_OVERFLOW_EN
    chk("abort_ovf", bus.overflow, 0);
`endif
    resetn = 1'b1;
    done_n = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) done_n++;
    end
    chk("abort_no_done", done_n, 0);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      run_op(v, lat);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_result", i), bus.result, v.res);
      chk($sformatf("v%0d_carryout", i), bus.carryout, v.cout);
      chk($sformatf("v%0d_zero", i), bus.zero, v.zero);
      chk($sformatf("v%0d_sgt", i), bus.sgt, v.sgt);
`ifdef BITSERIAL_ALU_OVERFLOW_EN
      chk($sformatf("v%0d_overflow", i), bus.overflow, v.ovf);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("v%0d_hold", i), bus.result, v.res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
